// File: rtl/rc4_decrypt.sv
// rc4_decrypt: streaming RC4 decryptor for 32-bit words under a 32-bit key.
// A key_load pulse runs INIT + KSA (plus an optional 256-byte keystream drop),
// then each accepted ciphertext word is XORed with the next four keystream
// bytes. The PRGA indices persist across words, so the keystream is continuous.
//
// Build option: define RC4_DROP_EN to discard the first 256 keystream bytes
// after key scheduling (RC4-drop[256]). Key-load latency is then 768 cycles
// instead of 512.
module rc4_decrypt (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] key,
    input  logic        key_load,
    output logic        busy,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ctxt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] ptxt
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSA,
`ifdef RC4_DROP_EN
        DROP,
`endif
        READY,
        GEN,
        OUT
    } state_t;

    state_t      state;
    logic [7:0]  cnt;      // i in INIT, l in KSA, step in DROP, byte n in GEN
    logic [7:0]  a;        // PRGA index i
    logic [7:0]  b;        // PRGA index j
    logic [7:0]  m;        // KSA index j
    logic [31:0] key_r;
    logic [31:0] word_r;   // latched ciphertext, decrypted in place byte by byte

    // RC4 state array, one register per entry so that a full swap fits in
    // one cycle (two reads, two writes).
    logic [7:0]  s [256];

    // Key-scheduling datapath: m' = m + S[l] + K[l mod 4].
    logic [7:0]  k_byte;
    logic [7:0]  s_l;
    logic [7:0]  m_next;
    logic [7:0]  s_m;

    // PRGA datapath: a' = a + 1, b' = b + S[a'], keystream byte taken from
    // the post-swap array at index S[a'] + S[b'].
    logic [7:0]  a_next;
    logic [7:0]  s_a;
    logic [7:0]  b_next;
    logic [7:0]  s_b;
    logic [7:0]  t_idx;
    logic [7:0]  ks_byte;
    logic [7:0]  dec_byte;

    // State-array write ports.
    logic        we0;
    logic        we1;
    logic [7:0]  addr0;
    logic [7:0]  addr1;
    logic [7:0]  data0;
    logic [7:0]  data1;

    assign k_byte   = key_r[{cnt[1:0], 3'b000} +: 8];
    assign s_l      = s[cnt];
    assign m_next   = m + s_l + k_byte;
    assign s_m      = s[m_next];

    assign a_next   = a + 8'd1;
    assign s_a      = s[a_next];
    assign b_next   = b + s_a;
    assign s_b      = s[b_next];
    assign t_idx    = s_a + s_b;
    assign dec_byte = word_r[{cnt[1:0], 3'b000} +: 8] ^ ks_byte;

    // Keystream byte as seen after this cycle's swap: the two swapped entries
    // have exchanged values, every other entry is unchanged.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        ks_byte = s[t_idx];
        if (t_idx == a_next)
            ks_byte = s_b;
        else if (t_idx == b_next)
            ks_byte = s_a;
    end

    // Select what each state writes into the state array this cycle.
    always_comb begin
        we0   = 1'b0;
        we1   = 1'b0;
        addr0 = 8'd0;
        addr1 = 8'd0;
        data0 = 8'd0;
        data1 = 8'd0;
        unique case (state)
            INIT: begin
                we0   = 1'b1;
                addr0 = cnt;
                data0 = cnt;
            end
            KSA: begin
                we0   = 1'b1;
                addr0 = cnt;
                data0 = s_m;
                we1   = 1'b1;
                addr1 = m_next;
                data1 = s_l;
            end
`ifdef RC4_DROP_EN
            DROP,
`endif
            GEN: begin
                we0   = 1'b1;
                addr0 = a_next;
                data0 = s_b;
                we1   = 1'b1;
                addr1 = b_next;
                data1 = s_a;
            end
            default: ;
        endcase
        // Reset and key reload abandon whatever step was in flight.
        if (rst || key_load) begin
            we0 = 1'b0;
            we1 = 1'b0;
        end
    end

    // State array update; a swap of an entry with itself writes the same value twice.
    // NOTE: the state array has no reset; INIT rewrites every entry before any read.
    always_ff @(posedge clk) begin
        if (we0)
            s[addr0] <= data0;
        if (we1)
            s[addr1] <= data1;
    end

    // Control FSM with registered handshake outputs and plaintext.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // read in this block sees the value from before the clock edge.
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            a         <= 8'd0;
            b         <= 8'd0;
            m         <= 8'd0;
            key_r     <= 32'h0;
            word_r    <= 32'h0;
            ptxt      <= 32'h0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else if (key_load) begin
            state     <= INIT;
            key_r     <= key;
            cnt       <= 8'd0;
            a         <= 8'd0;
            b         <= 8'd0;
            m         <= 8'd0;
            busy      <= 1'b1;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: ;
                INIT: begin
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'd255)
                        state <= KSA;
                end
                KSA: begin
                    m   <= m_next;
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'd255) begin
`ifdef RC4_DROP_EN
                        state    <= DROP;
`else
                        state    <= READY;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
`endif
                    end
                end
`ifdef RC4_DROP_EN
                DROP: begin
                    a   <= a_next;
                    b   <= b_next;
                    cnt <= cnt + 8'd1;
                    if (cnt == 8'd255) begin
                        state    <= READY;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end
                end
`endif
                READY: begin
                    if (in_valid) begin
                        word_r   <= ctxt;
                        cnt      <= 8'd0;
                        in_ready <= 1'b0;
                        state    <= GEN;
                    end
                end
                GEN: begin
                    a   <= a_next;
                    b   <= b_next;
                    cnt <= cnt + 8'd1;
                    word_r[{cnt[1:0], 3'b000} +: 8] <= dec_byte;
                    if (cnt[1:0] == 2'd3) begin
                        ptxt      <= {dec_byte, word_r[23:0]};
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= READY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
